// File: rtl/user_wrapper_demux_rd.sv
// rtl/user_wrapper_demux_rd.sv - packet demux: one AXI-Stream input routed to N_DESTS registered outputs
// Define AXIS_DEMUX_DROP_EN to discard and count packets addressed to an out-of-range port.
module user_wrapper_demux_rd #(
  parameter int N_DESTS       = 1,
  parameter int AXI_DATA_BITS = 64,
  parameter int PID_BITS      = 4
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [1:0]                                  port_in,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic [AXI_DATA_BITS-1:0]                    s_axis_tdata,
  input  logic [AXI_DATA_BITS/8-1:0]                  s_axis_tkeep,
  input  logic                                        s_axis_tlast,
  input  logic [PID_BITS-1:0]                         s_axis_tid,
  output logic [N_DESTS-1:0]                          m_axis_tvalid,
  input  logic [N_DESTS-1:0]                          m_axis_tready,
  output logic [N_DESTS-1:0][AXI_DATA_BITS-1:0]       m_axis_tdata,
  output logic [N_DESTS-1:0][AXI_DATA_BITS/8-1:0]     m_axis_tkeep,
  output logic [N_DESTS-1:0]                          m_axis_tlast,
  output logic [N_DESTS-1:0][PID_BITS-1:0]            m_axis_tid,
  output logic                                        busy,
  output logic [31:0]                                 drop_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t               state, state_nxt;
  logic [1:0]           dest_q;
  logic [1:0]           sel;
  logic                 in_range;
  logic                 drop_path;
  logic                 dst_ready;
  logic                 accept;
  logic [N_DESTS-1:0]   load;

  always_comb begin
    sel       = (state == IDLE) ? port_in : dest_q;
    in_range  = (32'(port_in) < N_DESTS);
`ifdef AXIS_DEMUX_DROP_EN
    drop_path = (state == DROP) || ((state == IDLE) && !in_range);
`else
    drop_path = 1'b0;
`endif
    dst_ready = 1'b0;
    for (int i = 0; i < N_DESTS; i++) begin
      if (sel == 2'(i)) dst_ready = !m_axis_tvalid[i] || m_axis_tready[i];
    end
    // An unroutable first beat stalls the input unless it is being dropped.
    if (areset)
      s_axis_tready = 1'b0;
    else if (drop_path)
      s_axis_tready = 1'b1;
    else if ((state == IDLE) && !in_range)
      s_axis_tready = 1'b0;
    else
      s_axis_tready = dst_ready;
    accept = s_axis_tvalid && s_axis_tready;
    load   = '0;
    for (int i = 0; i < N_DESTS; i++) begin
      load[i] = accept && !drop_path && (sel == 2'(i));
    end
    state_nxt = state;
    case (state)
      IDLE:      if (accept && !s_axis_tlast) state_nxt = drop_path ? DROP : FWD;
      FWD, DROP: if (accept && s_axis_tlast)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      dest_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept && (state == IDLE)) dest_q <= port_in;
    end
  end

  // One-entry output slot per destination; a load while draining keeps it full.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= '0;
      m_axis_tid    <= '0;
    end else begin
      for (int i = 0; i < N_DESTS; i++) begin
        if (load[i]) begin
          m_axis_tvalid[i] <= 1'b1;
          m_axis_tdata[i]  <= s_axis_tdata;
          m_axis_tkeep[i]  <= s_axis_tkeep;
          m_axis_tlast[i]  <= s_axis_tlast;
          m_axis_tid[i]    <= s_axis_tid;
        end else if (m_axis_tready[i]) begin
          m_axis_tvalid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef AXIS_DEMUX_DROP_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      drop_cnt <= '0;
    else if (accept && (state == IDLE) && drop_path && (drop_cnt != 32'hFFFF_FFFF))
      drop_cnt <= drop_cnt + 32'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_user_wrapper_demux_rd.sv
// tb/tb_user_wrapper_demux_rd.sv - scoreboard bench for user_wrapper_demux_rd (4-dest and 2-dest instances)
module tb_user_wrapper_demux_rd;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic             aclk = 1'b0;
  logic             areset;
  int               checks = 0;
  int               errors = 0;

  logic [1:0]       port_in;
  logic             s_tvalid, s_tready, s_tlast;
  logic [63:0]      s_tdata;
  logic [7:0]       s_tkeep;
  logic [3:0]       s_tid;
  logic [3:0]       m_tvalid, m_tready, m_tlast;
  logic [3:0][63:0] m_tdata;
  logic [3:0][7:0]  m_tkeep;
  logic [3:0][3:0]  m_tid;
  logic             busy;
  logic [31:0]      drop_cnt;

  logic [1:0]       d2_port_in;
  logic             d2_tvalid, d2_tready, d2_tlast;
  logic [63:0]      d2_tdata;
  logic [7:0]       d2_tkeep;
  logic [3:0]       d2_tid;
  logic [1:0]       d2_m_tvalid, d2_m_tready, d2_m_tlast;
  logic [1:0][63:0] d2_m_tdata;
  logic [1:0][7:0]  d2_m_tkeep;
  logic [1:0][3:0]  d2_m_tid;
  logic             d2_busy;
  logic [31:0]      d2_drop_cnt;

  beat_t exp_q[4][$];

  always #5 aclk = ~aclk;

  user_wrapper_demux_rd #(.N_DESTS(4), .AXI_DATA_BITS(64), .PID_BITS(4)) u_dut4 (
    .aclk(aclk), .areset(areset), .port_in(port_in),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  user_wrapper_demux_rd #(.N_DESTS(2), .AXI_DATA_BITS(64), .PID_BITS(4)) u_dut2 (
    .aclk(aclk), .areset(areset), .port_in(d2_port_in),
    .s_axis_tvalid(d2_tvalid), .s_axis_tready(d2_tready), .s_axis_tdata(d2_tdata),
    .s_axis_tkeep(d2_tkeep), .s_axis_tlast(d2_tlast), .s_axis_tid(d2_tid),
    .m_axis_tvalid(d2_m_tvalid), .m_axis_tready(d2_m_tready), .m_axis_tdata(d2_m_tdata),
    .m_axis_tkeep(d2_m_tkeep), .m_axis_tlast(d2_m_tlast), .m_axis_tid(d2_m_tid),
    .busy(d2_busy), .drop_cnt(d2_drop_cnt)
  );

  // Output monitor: every handshake on the 4-dest instance pops its destination queue.
  always @(negedge aclk) begin
    for (int i = 0; i < 4; i++) begin
      if (m_tvalid[i] && m_tready[i]) begin
        beat_t got, exp;
        got = {m_tdata[i], m_tkeep[i], m_tlast[i], m_tid[i]};
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL m%0d_unexpected_beat got=%h required=none", i, got);
        end else begin
          exp = exp_q[i].pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL m%0d_beat got=%h required=%h", i, got, exp);
          end
        end
      end
    end
  end

  task automatic send_beat(input int dest, input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic [3:0] id, output int waits);
    beat_t b;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tid = id;
    waits = 0;
    @(negedge aclk);
    while (!s_tready && waits < 50) begin
      waits++;
      @(negedge aclk);
    end
    checks++;
    if (!s_tready) begin
      errors++;
      $display("FAIL send_timeout tready=%b required=1", s_tready);
    end else begin
      b = {d, k, l, id};
      exp_q[dest].push_back(b);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    port_in = 2'd0; s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tid = '0;
    m_tready = 4'b1111;
    d2_port_in = 2'd0; d2_tvalid = 0; d2_tdata = '0; d2_tkeep = '0; d2_tlast = 0; d2_tid = '0;
    d2_m_tready = 2'b11;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (m_tvalid !== 4'b0) begin errors++; $display("FAIL rst_tvalid got=%b required=0000", m_tvalid); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%b required=0", s_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
    checks++; if (drop_cnt !== 32'd0 || d2_drop_cnt !== 32'd0) begin errors++; $display("FAIL rst_drop_cnt got=%0d/%0d required=0", drop_cnt, d2_drop_cnt); end
    checks++; if (m_tdata !== '0 || m_tid !== '0 || m_tlast !== '0) begin errors++; $display("FAIL rst_mdata got=%h required=0", m_tdata); end
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic;
    int w;
    port_in = 2'd2;
    for (int b = 0; b < 4; b++) begin
      logic [63:0] d;
      d = 64'hA5A5_0000_0000_0000 | 64'(b);
      send_beat(2, d, 8'hF0 | 8'(b), (b == 3), 4'(b + 5), w);
      checks++; if (w != 0) begin errors++; $display("FAIL basic_wait beat=%0d got=%0d required=0", b, w); end
      checks++; if (m_tvalid !== 4'b0100 || m_tdata[2] !== d) begin errors++; $display("FAIL basic_latency beat=%0d tvalid=%b data=%h required=0100/%h", b, m_tvalid, m_tdata[2], d); end
      checks++; if (busy !== (b != 3)) begin errors++; $display("FAIL basic_busy beat=%0d got=%b required=%b", b, busy, (b != 3)); end
    end
    checks++; if (m_tlast[2] !== 1'b1) begin errors++; $display("FAIL basic_tlast got=%b required=1", m_tlast[2]); end
  endtask

  task automatic test_port_switch;
    int w;
    port_in = 2'd2;
    send_beat(2, 64'h1111, 8'hFF, 1'b0, 4'h1, w);
    port_in = 2'd0;
    send_beat(2, 64'h2222, 8'h0F, 1'b0, 4'h2, w);
    send_beat(2, 64'h3333, 8'h03, 1'b1, 4'h3, w);
    send_beat(0, 64'h4444, 8'hFF, 1'b0, 4'h4, w);
    checks++; if (m_tvalid !== 4'b0001) begin errors++; $display("FAIL switch_next_dest got=%b required=0001", m_tvalid); end
    send_beat(0, 64'h5555, 8'h01, 1'b1, 4'h5, w);
  endtask

  task automatic test_backpressure;
    int w;
    port_in = 2'd1;
    send_beat(1, 64'hB001, 8'hFF, 1'b0, 4'h7, w);
    send_beat(1, 64'hB002, 8'hFF, 1'b0, 4'h7, w);
    m_tready[1] = 1'b0;
    s_tvalid = 1'b1; s_tdata = 64'hB003; s_tkeep = 8'h3C; s_tlast = 1'b0; s_tid = 4'h7;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_tready cyc=%0d got=%b required=0", c, s_tready); end
      checks++; if (m_tvalid[1] !== 1'b1 || m_tdata[1] !== 64'hB002) begin errors++; $display("FAIL bp_hold cyc=%0d data=%h required=b002", c, m_tdata[1]); end
    end
    @(posedge aclk); #1;
    m_tready[1] = 1'b1;
    send_beat(1, 64'hB003, 8'h3C, 1'b0, 4'h7, w);
    checks++; if (w != 0) begin errors++; $display("FAIL bp_resume_wait got=%0d required=0", w); end
    send_beat(1, 64'hB004, 8'hFF, 1'b0, 4'h7, w);
    checks++; if (w != 0) begin errors++; $display("FAIL bp_rate_wait got=%0d required=0", w); end
    send_beat(1, 64'hB005, 8'h81, 1'b1, 4'h7, w);
  endtask

  task automatic test_back_to_back;
    int w;
    logic [1:0] ports [4];
    ports[0] = 2'd0; ports[1] = 2'd1; ports[2] = 2'd3; ports[3] = 2'd0;
    for (int p = 0; p < 4; p++) begin
      port_in = ports[p];
      send_beat(int'(ports[p]), 64'hC000 | 64'(p), 8'hFF, 1'b1, 4'(p), w);
      checks++; if (w != 0) begin errors++; $display("FAIL b2b_wait pkt=%0d got=%0d required=0", p, w); end
      checks++; if (m_tvalid !== (4'b1 << ports[p]) || busy !== 1'b0) begin errors++; $display("FAIL b2b_route pkt=%0d tvalid=%b busy=%b required=%b/0", p, m_tvalid, busy, 4'b1 << ports[p]); end
    end
  endtask

  task automatic test_reset_mid;
    int w;
    port_in = 2'd2;
    send_beat(2, 64'hD001, 8'hFF, 1'b0, 4'h9, w);
    s_tvalid = 1'b1; s_tdata = 64'hD002; s_tkeep = 8'hFF; s_tlast = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    #1;
    checks++; if (m_tvalid !== 4'b0 || busy !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL rstmid_clear tvalid=%b busy=%b tready=%b required=0000/0/0", m_tvalid, busy, s_tready); end
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    port_in = 2'd1;
    send_beat(1, 64'hD003, 8'hFF, 1'b0, 4'h9, w);
    checks++; if (m_tvalid !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_new_pkt tvalid=%b busy=%b required=0010/1", m_tvalid, busy); end
    port_in = 2'd3;
    send_beat(1, 64'hD004, 8'hFF, 1'b1, 4'h9, w);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_end busy=%b required=0", busy); end
  endtask

  task automatic test_drop;
    d2_port_in = 2'd3;
    d2_tvalid = 1'b1; d2_tdata = 64'hE001; d2_tkeep = 8'hFF; d2_tlast = 1'b0; d2_tid = 4'hE;
`ifdef AXIS_DEMUX_DROP_EN
    @(negedge aclk);
    checks++; if (d2_tready !== 1'b1) begin errors++; $display("FAIL drop_tready1 got=%b required=1", d2_tready); end
    @(posedge aclk); #1;
    checks++; if (d2_m_tvalid !== 2'b0 || d2_busy !== 1'b1 || d2_drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_first tvalid=%b busy=%b cnt=%0d required=00/1/1", d2_m_tvalid, d2_busy, d2_drop_cnt); end
    d2_tdata = 64'hE002; d2_tlast = 1'b1;
    @(negedge aclk);
    checks++; if (d2_tready !== 1'b1) begin errors++; $display("FAIL drop_tready2 got=%b required=1", d2_tready); end
    @(posedge aclk); #1;
    d2_tvalid = 1'b0;
    checks++; if (d2_m_tvalid !== 2'b0 || d2_busy !== 1'b0 || d2_drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_end tvalid=%b busy=%b cnt=%0d required=00/0/1", d2_m_tvalid, d2_busy, d2_drop_cnt); end
`else
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++; if (d2_tready !== 1'b0) begin errors++; $display("FAIL stall_tready cyc=%0d got=%b required=0", c, d2_tready); end
    end
    @(posedge aclk); #1;
    d2_port_in = 2'd1;
    @(negedge aclk);
    checks++; if (d2_tready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b required=1", d2_tready); end
    @(posedge aclk); #1;
    checks++; if (d2_m_tvalid !== 2'b10 || d2_m_tdata[1] !== 64'hE001 || d2_busy !== 1'b1) begin errors++; $display("FAIL stall_beat1 tvalid=%b data=%h busy=%b required=10/e001/1", d2_m_tvalid, d2_m_tdata[1], d2_busy); end
    d2_port_in = 2'd3; d2_tdata = 64'hE002; d2_tlast = 1'b1;
    @(negedge aclk);
    checks++; if (d2_tready !== 1'b1) begin errors++; $display("FAIL stall_fwd_ignores_port got=%b required=1", d2_tready); end
    @(posedge aclk); #1;
    d2_tvalid = 1'b0;
    checks++; if (d2_m_tvalid !== 2'b10 || d2_m_tdata[1] !== 64'hE002 || d2_m_tlast[1] !== 1'b1 || d2_busy !== 1'b0 || d2_drop_cnt !== 32'd0) begin errors++; $display("FAIL stall_beat2 tvalid=%b data=%h busy=%b cnt=%0d required=10/e002/0/0", d2_m_tvalid, d2_m_tdata[1], d2_busy, d2_drop_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_port_switch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    repeat (5) @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL m%0d_leftover got=%0d beats required=0", i, exp_q[i].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
